// File: rtl/img_ctrl_pkg.sv
// rtl/img_ctrl_pkg.sv - shared types and constants for the image memory controller
//
// Purpose: FSM state encoding, remap mode codes, default frame geometry and
// the mode decode helpers shared by the controller and its address generator.
package img_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_COPY   = 2'd0;
  localparam logic [1:0] MODE_HFLIP  = 2'd1;
  localparam logic [1:0] MODE_VFLIP  = 2'd2;
  localparam logic [1:0] MODE_ROT180 = 2'd3;

  localparam int DEF_IMG_W = 800;
  localparam int DEF_IMG_H = 600;

  // Column mirrored in hflip and rot180.
  function automatic logic flip_h(input logic [1:0] mode);
    return (mode == MODE_HFLIP) || (mode == MODE_ROT180);
  endfunction

  // Row mirrored in vflip and rot180.
  function automatic logic flip_v(input logic [1:0] mode);
    return (mode == MODE_VFLIP) || (mode == MODE_ROT180);
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// rtl/raster_addr_gen.sv - raster x/y counters with source and remapped destination addresses
//
// Purpose: walks the frame in raster order and produces the linear source
// address and the mode-remapped destination address without multipliers.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_clear         restart at pixel (0,0)
//   i_advance       step to the next raster position
//   i_mode_q        latched remap mode
//   o_src, o_dst    source / destination address, zero-extended to ADDR_W
//   o_last          current position is the last pixel of the frame
module raster_addr_gen
  import img_ctrl_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [1:0]        i_mode_q,
  output logic [ADDR_W-1:0] o_src,
  output logic [ADDR_W-1:0] o_dst,
  output logic              o_last
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     X_LAST       = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST       = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_STEP       = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_REV_INIT = ADDR_W'((IMG_H - 1) * IMG_W);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  // Both row bases are kept so the mode only selects, never recomputes:
  // r_row_fwd = y*W, r_row_rev = (H-1-y)*W.
  logic [ADDR_W-1:0] r_row_fwd;
  logic [ADDR_W-1:0] r_row_rev;
  logic [XW-1:0]     w_col;
  logic [ADDR_W-1:0] w_row;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_x       <= '0;
      r_y       <= '0;
      r_row_fwd <= '0;
      r_row_rev <= ROW_REV_INIT;
    end else if (i_advance) begin
      if (r_x == X_LAST) begin
        r_x       <= '0;
        r_y       <= r_y + 1'b1;
        r_row_fwd <= r_row_fwd + W_STEP;
        r_row_rev <= r_row_rev - W_STEP;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_col  = flip_h(i_mode_q) ? (X_LAST - r_x) : r_x;
  assign w_row  = flip_v(i_mode_q) ? r_row_rev : r_row_fwd;
  assign o_src  = r_row_fwd + ADDR_W'(r_x);
  assign o_dst  = w_row + ADDR_W'(w_col);
  assign o_last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/img_mem_ctrl_param.sv
// rtl/img_mem_ctrl_param.sv - parametrised frame copy/remap memory controller
//
// Purpose: per pixel READ (1 cycle), WAIT (RD_LAT cycles), WRITE (1 cycle);
// frame started by i_start in IDLE/DONE, completion held on o_done.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_mode              frame start request and remap mode
//   o_en_in_mem, o_in_mem_addr   input memory read enable / address
//   o_en_out_mem, o_out_mem_read, o_out_mem_write, o_out_mem_addr
//                                output memory enable / strobes / address
//   o_pix_valid                  read data valid at the datapath
//   o_busy, o_done               frame in progress / frame complete
module img_mem_ctrl_param
  import img_ctrl_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  output logic              o_en_in_mem,
  output logic [ADDR_W-1:0] o_in_mem_addr,
  output logic              o_en_out_mem,
  output logic              o_out_mem_read,
  output logic              o_out_mem_write,
  output logic [ADDR_W-1:0] o_out_mem_addr,
  output logic              o_pix_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WW-1:0]     r_wait;
  logic [1:0]        r_mode_q;
  logic              w_accept;
  logic              w_advance;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;
  logic              w_last;

  raster_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_accept),
    .i_advance (w_advance),
    .i_mode_q  (r_mode_q),
    .o_src     (w_src),
    .o_dst     (w_dst),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_mode_q <= MODE_COPY;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode_q <= i_mode;
      end
      // Counter runs only inside WAIT and is back at 0 whenever WAIT is entered.
      if (r_state == S_WAIT && r_wait != WAIT_LAST) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    w_advance       = 1'b0;
    o_en_in_mem     = 1'b0;
    o_in_mem_addr   = '0;
    o_en_out_mem    = 1'b0;
    o_out_mem_read  = 1'b0;
    o_out_mem_write = 1'b0;
    o_out_mem_addr  = '0;
    o_pix_valid     = 1'b0;
    o_busy          = 1'b0;
    o_done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end
      end
      S_READ: begin
        o_busy        = 1'b1;
        o_en_in_mem   = 1'b1;
        o_in_mem_addr = w_src;
        w_next        = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (r_wait == WAIT_LAST) begin
          o_pix_valid = 1'b1;
          w_next      = S_WRITE;
        end
      end
      S_WRITE: begin
        o_busy          = 1'b1;
        o_en_out_mem    = 1'b1;
        o_out_mem_write = 1'b1;
        o_out_mem_addr  = w_dst;
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_advance = 1'b1;
          w_next    = S_READ;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_img_mem_ctrl_param.sv
// tb/tb_img_mem_ctrl_param.sv - directed self-checking bench for img_mem_ctrl_param
module tb_img_mem_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a;
  logic [1:0]  mode_a;
  logic        en_in_a, en_out_a, rd_a, wr_a, pv_a, busy_a, done_a;
  logic [15:0] in_addr_a, out_addr_a;

  logic        rst_b, start_b;
  logic [1:0]  mode_b;
  logic        en_in_b, en_out_b, rd_b, wr_b, pv_b, busy_b, done_b;
  logic [15:0] in_addr_b, out_addr_b;

  img_mem_ctrl_param #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .RD_LAT(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_mode(mode_a),
    .o_en_in_mem(en_in_a), .o_in_mem_addr(in_addr_a),
    .o_en_out_mem(en_out_a), .o_out_mem_read(rd_a), .o_out_mem_write(wr_a),
    .o_out_mem_addr(out_addr_a), .o_pix_valid(pv_a), .o_busy(busy_a), .o_done(done_a)
  );

  img_mem_ctrl_param #(.IMG_W(2), .IMG_H(2), .ADDR_W(16), .RD_LAT(3)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_mode(mode_b),
    .o_en_in_mem(en_in_b), .o_in_mem_addr(in_addr_b),
    .o_en_out_mem(en_out_b), .o_out_mem_read(rd_b), .o_out_mem_write(wr_b),
    .o_out_mem_addr(out_addr_b), .o_pix_valid(pv_b), .o_busy(busy_b), .o_done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed write address order for a 4x3 frame, indexed by mode.
  int exp_tab[4][12] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11},
    '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8},
    '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3},
    '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; the following posedge accepts start (cycle 0).
  task automatic run_a(input int m, input bit disturb);
    int ridx;
    int widx;
    int ew;
    ridx = 0;
    widx = 0;
    mode_a  = 2'(m);
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 37; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start_a = 1'b0;
        check($sformatf("m%0d_c1_done", m), done_a, 0);
        check($sformatf("m%0d_c1_busy", m), busy_a, 1);
      end
      if (disturb && cyc == 10) begin
        start_a = 1'b1;
        mode_a  = 2'(3 - m);
      end
      if (disturb && cyc == 12) start_a = 1'b0;
      if (en_in_a) begin
        check($sformatf("m%0d_rd_addr%0d", m, ridx), in_addr_a, ridx);
        check($sformatf("m%0d_rd_cyc%0d", m, ridx), cyc, 1 + 3 * ridx);
        ridx++;
      end
      if (wr_a) begin
        ew = (widx < 12) ? exp_tab[m][widx] : -1;
        check($sformatf("m%0d_wr_addr%0d", m, widx), out_addr_a, ew);
        check($sformatf("m%0d_wr_cyc%0d", m, widx), cyc, 3 + 3 * widx);
        check($sformatf("m%0d_wr_en%0d", m, widx), {en_out_a, rd_a}, 2'b10);
        widx++;
      end
      if (cyc == 36) check($sformatf("m%0d_done_c36", m), {done_a, busy_a}, 2'b01);
      if (cyc == 37) check($sformatf("m%0d_done_c37", m), {done_a, busy_a}, 2'b10);
    end
    check($sformatf("m%0d_n_reads", m), ridx, 12);
    check($sformatf("m%0d_n_writes", m), widx, 12);
  endtask

  task automatic run_b();
    int ridx;
    int pidx;
    int widx;
    ridx = 0;
    pidx = 0;
    widx = 0;
    mode_b  = 2'd0;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (en_in_b) begin
        check($sformatf("b_rd_addr%0d", ridx), in_addr_b, ridx);
        check($sformatf("b_rd_cyc%0d", ridx), cyc, 1 + 5 * ridx);
        ridx++;
      end
      if (pv_b) begin
        check($sformatf("b_pv_cyc%0d", pidx), cyc, 4 + 5 * pidx);
        pidx++;
      end
      if (wr_b) begin
        check($sformatf("b_wr_addr%0d", widx), out_addr_b, widx);
        check($sformatf("b_wr_cyc%0d", widx), cyc, 5 + 5 * widx);
        widx++;
      end
      if (cyc == 20) check("b_done_c20", done_b, 0);
      if (cyc == 21) check("b_done_c21", {done_b, busy_b}, 2'b10);
    end
    check("b_n_reads", ridx, 4);
    check("b_n_pv", pidx, 4);
    check("b_n_writes", widx, 4);
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; mode_a = 2'd0;
    rst_b = 1'b1; start_b = 1'b0; mode_b = 2'd0;
    repeat (3) @(negedge clk);
    check("a_reset_outs", {en_in_a, en_out_a, rd_a, wr_a, pv_a, busy_a, done_a}, 0);
    check("a_reset_addrs", {in_addr_a, out_addr_a}, 0);
    check("b_reset_outs", {en_in_b, en_out_b, rd_b, wr_b, pv_b, busy_b, done_b}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("a_idle_busy", {busy_a, done_a}, 0);

    run_a(0, 1'b0);
    run_a(1, 1'b0);
    run_a(2, 1'b0);
    run_a(3, 1'b0);
    run_a(0, 1'b1);
    run_a(3, 1'b0);

    // Reset during pixel 5's WRITE.
    mode_a  = 2'd0;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check("rst_pre_write", {wr_a, 16'(out_addr_a)}, {1'b1, 16'd5});
    rst_a = 1'b1;
    @(negedge clk);
    check("rst_outs", {en_in_a, en_out_a, rd_a, wr_a, pv_a, busy_a, done_a}, 0);
    check("rst_addrs", {in_addr_a, out_addr_a}, 0);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_quiet", {en_in_a, en_out_a, wr_a, busy_a, done_a}, 0);
    run_a(0, 1'b0);

    run_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
